// File: rtl/clkgen_multi.sv
// Multi-channel clock-enable generator: per-channel programmable divisor, one-cycle tick and 50% square wave.
// Optional phase-alignment input sync_in is present only when CLKGEN_SYNC_EN is defined.
module clkgen_multi #(
  parameter int CH   = 2,
  parameter int W    = 16,
  parameter int DIV0 = 1000
) (
  input  logic          clk,
  input  logic          clr,
  input  logic          en,
  input  logic [CH-1:0] ld,
  input  logic [W-1:0]  div_in,
  output logic [CH-1:0] tick,
  output logic [CH-1:0] sq,
  output logic [CH-1:0] ld_pend
`ifdef CLKGEN_SYNC_EN
  ,
  input  logic          sync_in
`endif
);

  logic [W-1:0]  cnt_q  [CH];
  logic [W-1:0]  cnt_d  [CH];
  logic [W-1:0]  div_q  [CH];
  logic [W-1:0]  div_d  [CH];
  logic [W-1:0]  pend_q [CH];
  logic [W-1:0]  pend_d [CH];
  logic [CH-1:0] tick_q, tick_d;
  logic [CH-1:0] sq_q, sq_d;
  logic [CH-1:0] ldp_q, ldp_d;

  logic [W-1:0]  d_eff  [CH];
  logic [CH-1:0] term;

  // A programmed divisor of zero is treated as one so the channel never stalls.
  for (genvar g = 0; g < CH; g++) begin : g_term
    assign d_eff[g] = (div_q[g] == '0) ? W'(1) : div_q[g];
    assign term[g]  = en && (cnt_q[g] == d_eff[g] - W'(1));
  end

  always_comb begin
    cnt_d  = cnt_q;
    div_d  = div_q;
    pend_d = pend_q;
    tick_d = '0;
    sq_d   = sq_q;
    ldp_d  = ldp_q;
    for (int i = 0; i < CH; i++) begin
      if (ld[i]) begin
        pend_d[i] = div_in;
      end
      if (term[i]) begin
        cnt_d[i]  = '0;
        tick_d[i] = 1'b1;
        sq_d[i]   = ~sq_q[i];
        // A load landing on the terminal edge bypasses the pending register.
        if (ld[i]) begin
          div_d[i] = div_in;
          ldp_d[i] = 1'b0;
        end else if (ldp_q[i]) begin
          div_d[i] = pend_q[i];
          ldp_d[i] = 1'b0;
        end
      end else begin
        if (en) begin
          cnt_d[i] = cnt_q[i] + W'(1);
        end
        if (ld[i]) begin
          ldp_d[i] = 1'b1;
        end
      end
`ifdef CLKGEN_SYNC_EN
      // Alignment restarts every channel and commits waiting divisors; loads this cycle are dropped.
      if (sync_in) begin
        cnt_d[i]  = '0;
        pend_d[i] = pend_q[i];
        div_d[i]  = ldp_q[i] ? pend_q[i] : div_q[i];
        tick_d[i] = 1'b0;
        sq_d[i]   = 1'b0;
        ldp_d[i]  = 1'b0;
      end
`endif
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      for (int i = 0; i < CH; i++) begin
        cnt_q[i]  <= '0;
        div_q[i]  <= W'(DIV0);
        pend_q[i] <= W'(DIV0);
      end
      tick_q <= '0;
      sq_q   <= '0;
      ldp_q  <= '0;
    end else begin
      cnt_q  <= cnt_d;
      div_q  <= div_d;
      pend_q <= pend_d;
      tick_q <= tick_d;
      sq_q   <= sq_d;
      ldp_q  <= ldp_d;
    end
  end

  assign tick    = tick_q;
  assign sq      = sq_q;
  assign ld_pend = ldp_q;

endmodule

// File: tb/tb_clkgen_multi.sv
// Directed bench for clkgen_multi with CH=2, DIV0=4; edge n is the n-th enabled edge after reset release.
module tb_clkgen_multi;
  localparam int CH   = 2;
  localparam int W    = 16;
  localparam int DIV0 = 4;

  logic          clk = 1'b0;
  logic          clr;
  logic          en;
  logic [CH-1:0] ld;
  logic [W-1:0]  div_in;
  logic [CH-1:0] tick;
  logic [CH-1:0] sq;
  logic [CH-1:0] ld_pend;
`ifdef CLKGEN_SYNC_EN
  logic          sync_in;
`endif

  int total = 0;
  int bad   = 0;

  clkgen_multi #(.CH(CH), .W(W), .DIV0(DIV0)) dut (
    .clk     (clk),
    .clr     (clr),
    .en      (en),
    .ld      (ld),
    .div_in  (div_in),
    .tick    (tick),
    .sq      (sq),
    .ld_pend (ld_pend)
`ifdef CLKGEN_SYNC_EN
    ,
    .sync_in (sync_in)
`endif
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    clr = 1'b1; en = 1'b0; ld = '0; div_in = '0;
`ifdef CLKGEN_SYNC_EN
    sync_in = 1'b0;
`endif
    step();
    step();
    clr = 1'b0; en = 1'b1;
  endtask

  task automatic test_reset();
    clr = 1'b1; en = 1'b1; ld = 2'b11; div_in = 16'd9;
`ifdef CLKGEN_SYNC_EN
    sync_in = 1'b0;
`endif
    for (int n = 0; n < 3; n++) begin
      step();
      total++;
      if ({tick, sq, ld_pend} !== 6'b0) begin
        bad++;
        $display("FAIL reset cyc=%0d tick/sq/ld_pend=%b required=000000", n, {tick, sq, ld_pend});
      end
    end
    ld = '0;
  endtask

  task automatic test_defaults();
    logic [CH-1:0] et, es;
    do_reset();
    es = '0;
    for (int n = 1; n <= 13; n++) begin
      step();
      et = (n % 4 == 0) ? 2'b11 : 2'b00;
      es ^= et;
      total++;
      if ({tick, sq, ld_pend} !== {et, es, 2'b00}) begin
        bad++;
        $display("FAIL defaults edge=%0d tick/sq/ld_pend=%b required=%b", n, {tick, sq, ld_pend}, {et, es, 2'b00});
      end
    end
  endtask

  task automatic test_runtime_load();
    logic [CH-1:0] et, es, ep;
    do_reset();
    es = '0;
    for (int n = 1; n <= 12; n++) begin
      ld     = (n == 2 || n == 3) ? 2'b01 : 2'b00;
      div_in = (n == 2) ? 16'd5 : 16'd3;
      step();
      et[0] = (n == 4 || n == 7 || n == 10);
      et[1] = (n % 4 == 0);
      es ^= et;
      ep = (n == 2 || n == 3) ? 2'b01 : 2'b00;
      total++;
      if ({tick, sq, ld_pend} !== {et, es, ep}) begin
        bad++;
        $display("FAIL runtime_load edge=%0d tick/sq/ld_pend=%b required=%b", n, {tick, sq, ld_pend}, {et, es, ep});
      end
    end
    ld = '0;
  endtask

  task automatic test_boundary_bypass();
    logic [CH-1:0] et, es;
    do_reset();
    es = '0;
    for (int n = 1; n <= 14; n++) begin
      ld     = (n == 4) ? 2'b01 : (n == 8) ? 2'b10 : 2'b00;
      div_in = (n == 4) ? 16'd0 : 16'd1;
      step();
      et[0] = (n >= 4);
      et[1] = (n == 4 || n >= 8);
      es ^= et;
      total++;
      if ({tick, sq, ld_pend} !== {et, es, 2'b00}) begin
        bad++;
        $display("FAIL boundary edge=%0d tick/sq/ld_pend=%b required=%b", n, {tick, sq, ld_pend}, {et, es, 2'b00});
      end
    end
    ld = '0;
  endtask

  task automatic test_enable_gating();
    logic [CH-1:0] et, es;
    int ec;
    do_reset();
    es = '0;
    ec = 0;
    for (int k = 1; k <= 18; k++) begin
      en = !(k >= 6 && k <= 10);
      step();
      if (en) ec++;
      et = (en && ec % 4 == 0) ? 2'b11 : 2'b00;
      es ^= et;
      total++;
      if ({tick, sq, ld_pend} !== {et, es, 2'b00}) begin
        bad++;
        $display("FAIL enable_gating clk=%0d tick/sq/ld_pend=%b required=%b", k, {tick, sq, ld_pend}, {et, es, 2'b00});
      end
    end
    en = 1'b1;
  endtask

  task automatic test_clr_pending();
    logic [CH-1:0] et, es, ep;
    do_reset();
    es = '0;
    for (int n = 1; n <= 8; n++) begin
      ld     = (n == 1 || n == 7) ? 2'b01 : 2'b00;
      div_in = (n == 1) ? 16'd2 : 16'd7;
      clr    = (n == 8);
      step();
      et[0] = (n == 4 || n == 6);
      et[1] = (n == 4);
      es ^= et;
      ep = (n <= 3 || n == 7) ? 2'b01 : 2'b00;
      if (n == 8) begin
        et = '0; es = '0; ep = '0;
      end
      total++;
      if ({tick, sq, ld_pend} !== {et, es, ep}) begin
        bad++;
        $display("FAIL clr_pending edge=%0d tick/sq/ld_pend=%b required=%b", n, {tick, sq, ld_pend}, {et, es, ep});
      end
    end
    clr = 1'b0; ld = '0;
    es = '0;
    for (int m = 1; m <= 8; m++) begin
      step();
      et = (m % 4 == 0) ? 2'b11 : 2'b00;
      es ^= et;
      total++;
      if ({tick, sq, ld_pend} !== {et, es, 2'b00}) begin
        bad++;
        $display("FAIL clr_restart edge=%0d tick/sq/ld_pend=%b required=%b", m, {tick, sq, ld_pend}, {et, es, 2'b00});
      end
    end
  endtask

`ifdef CLKGEN_SYNC_EN
  task automatic test_sync();
    logic [CH-1:0] et, es, ep;
    do_reset();
    es = '0;
    for (int n = 1; n <= 20; n++) begin
      ld      = (n == 1) ? 2'b01 : (n == 2) ? 2'b10 : 2'b00;
      div_in  = (n == 1) ? 16'd3 : 16'd5;
      sync_in = (n == 14);
      step();
      et[0] = (n == 4) || (n > 4 && n < 14 && (n - 4) % 3 == 0) || (n > 14 && (n - 14) % 3 == 0);
      et[1] = (n == 4) || (n > 4 && n < 14 && (n - 4) % 5 == 0) || (n > 14 && (n - 14) % 5 == 0);
      es ^= et;
      if (n == 14) es = '0;
      ep[0] = (n >= 1 && n <= 3);
      ep[1] = (n >= 2 && n <= 3);
      total++;
      if ({tick, sq, ld_pend} !== {et, es, ep}) begin
        bad++;
        $display("FAIL sync edge=%0d tick/sq/ld_pend=%b required=%b", n, {tick, sq, ld_pend}, {et, es, ep});
      end
    end
    ld = '0; sync_in = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_defaults();
    test_runtime_load();
    test_boundary_bypass();
    test_enable_gating();
    test_clr_pending();
`ifdef CLKGEN_SYNC_EN
    test_sync();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
